// File: rtl/fft_fifo_prefetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_fifo_prefetch_ctrl_if
// Bus bundle for the FFT-stage prefetch FIFO.
//   master : the user side (drives flush/wr_en/wr_data/rd_en, sees status)
//   slave  : the FIFO itself
// Signals:
//   flush        sync clear, active-high
//   wr_en/wr_data/wr_vld   write request, data, space available
//   rd_en/rd_vld/rd_data   pop request, head valid, head word (FWFT)
//   count        words held, including the head register
//   almost_full/almost_empty  registered threshold flags
//   overflow/underflow        one-cycle error pulses
// ---------------------------------------------------------------------------
interface fft_fifo_prefetch_ctrl_if #(
    parameter int DEPTH_WIDTH = 11,
    parameter int DATA_WIDTH  = 64
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_vld;
    logic                  rd_en;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DEPTH_WIDTH:0]  count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  wr_vld, rd_vld, rd_data, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output wr_vld, rd_vld, rd_data, count,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fft_fifo_prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// fft_fifo_prefetch_ctrl
// Single-clock first-word-fall-through FIFO between FFT stages and the
// spectrum post-processing path. RAM array plus a prefetch output register;
// total capacity 2**DEPTH_WIDTH words (head register included in count).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-low (priority over flush)
//   bus   fft_fifo_prefetch_ctrl_if.slave (see interface header)
// ---------------------------------------------------------------------------
module fft_fifo_prefetch_ctrl #(
    parameter int DEPTH_WIDTH = 11,
    parameter int DATA_WIDTH  = 64,
    parameter int AFULL_TH    = 2**DEPTH_WIDTH - 8,
    parameter int AEMPTY_TH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    fft_fifo_prefetch_ctrl_if.slave  bus
);

    localparam int unsigned          CAP    = 2**DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] CAP_W  = (DEPTH_WIDTH+1)'(CAP);
    localparam logic [DEPTH_WIDTH:0] AF_LVL = (DEPTH_WIDTH+1)'(AFULL_TH);
    localparam logic [DEPTH_WIDTH:0] AE_LVL = (DEPTH_WIDTH+1)'(AEMPTY_TH);
    localparam logic [DEPTH_WIDTH:0] ONE    = (DEPTH_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_VALID
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [DATA_WIDTH-1:0]   r_mem [CAP];
    logic [DEPTH_WIDTH:0]    r_wr_ptr;
    logic [DEPTH_WIDTH:0]    r_rd_ptr;
    logic [DEPTH_WIDTH:0]    r_count;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_afull;
    logic                    r_aempty;
    logic                    r_ovf;
    logic                    r_udf;

    logic                    w_clr;
    logic                    w_wr_vld;
    logic                    w_rd_vld;
    logic                    w_wr_acc;
    logic                    w_pop;
    logic                    w_ram_empty;
    logic                    w_load;
    logic [DEPTH_WIDTH:0]    w_count_nxt;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_clr       = !rst || bus.flush;
        w_wr_vld    = (r_count != CAP_W);
        w_rd_vld    = (r_state == ST_VALID);
        w_wr_acc    = bus.wr_en && w_wr_vld;
        w_pop       = bus.rd_en && w_rd_vld;
        // RAM occupancy excludes the head register; rd_ptr only advances
        // when a word is moved into that register.
        w_ram_empty = (r_wr_ptr == r_rd_ptr);
        // LOADING always has a RAM word waiting; a pop refills immediately
        // from RAM when possible so streaming has no bubbles.
        w_load      = (r_state == ST_LOADING) || (w_pop && !w_ram_empty);
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_pop) begin
            w_count_nxt = r_count + ONE;
        end else if (!w_wr_acc && w_pop) begin
            w_count_nxt = r_count - ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Prefetch FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                // RAM is always empty here; it becomes non-empty on a write.
                if (w_wr_acc) begin
                    w_state_nxt = ST_LOADING;
                end
            end
            ST_LOADING: begin
                w_state_nxt = ST_VALID;
            end
            ST_VALID: begin
                if (w_pop) begin
                    if (!w_ram_empty) begin
                        w_state_nxt = ST_VALID;
                    end else if (w_wr_acc) begin
                        w_state_nxt = ST_LOADING;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage (no reset on the array; pointers make stale words unreachable)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!w_clr && w_wr_acc) begin
            r_mem[r_wr_ptr[DEPTH_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, head register, count, flags, error pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_load) begin
                r_rd_data <= r_mem[r_rd_ptr[DEPTH_WIDTH-1:0]];
                r_rd_ptr  <= r_rd_ptr + ONE;
            end
            r_count  <= w_count_nxt;
            // Flags come from next-count so they change with count itself.
            r_afull  <= (w_count_nxt >= AF_LVL);
            r_aempty <= (w_count_nxt <= AE_LVL);
            r_ovf    <= bus.wr_en && !w_wr_vld;
            r_udf    <= bus.rd_en && !w_rd_vld;
        end
    end

    assign bus.wr_vld       = w_wr_vld;
    assign bus.rd_vld       = w_rd_vld;
    assign bus.rd_data      = r_rd_data;
    assign bus.count        = r_count;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_fft_fifo_prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_fifo_prefetch_ctrl
// Directed bench for the prefetch FIFO (DEPTH_WIDTH=4, 16-bit data,
// AFULL_TH=8, AEMPTY_TH=3). A small queue model with per-word write
// timestamps supplies the per-cycle expectations; directed sections add
// hand-computed constants on top.
// ---------------------------------------------------------------------------
module tb_fft_fifo_prefetch_ctrl;

    localparam int DW   = 4;
    localparam int DATW = 16;
    localparam int AF   = 8;
    localparam int AE   = 3;
    localparam int CAPN = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fft_fifo_prefetch_ctrl_if #(.DEPTH_WIDTH(DW), .DATA_WIDTH(DATW)) bus ();

    fft_fifo_prefetch_ctrl #(
        .DEPTH_WIDTH (DW),
        .DATA_WIDTH  (DATW),
        .AFULL_TH    (AF),
        .AEMPTY_TH   (AE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model: queue of words plus the cycle each was accepted in
    logic [DATW-1:0] q  [$];
    int              qt [$];
    int              cyc   = 0;
    logic            m_ovf = 1'b0;
    logic            m_udf = 1'b0;
    logic            e_wr_vld;
    logic            e_rd_vld;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // A word accepted in cycle c is visible on rd_data from cycle c+2.
    task automatic model_exp();
        e_wr_vld = (q.size() != CAPN);
        e_rd_vld = (q.size() > 0) && (qt[0] <= cyc - 2);
    endtask

    task automatic compare_all();
        model_exp();
        check_val("count",        64'(bus.count),        64'(q.size()));
        check_val("wr_vld",       64'(bus.wr_vld),       64'(e_wr_vld));
        check_val("rd_vld",       64'(bus.rd_vld),       64'(e_rd_vld));
        check_val("almost_full",  64'(bus.almost_full),  64'(q.size() >= AF));
        check_val("almost_empty", 64'(bus.almost_empty), 64'(q.size() <= AE));
        check_val("overflow",     64'(bus.overflow),     64'(m_ovf));
        check_val("underflow",    64'(bus.underflow),    64'(m_udf));
        if (e_rd_vld) begin
            check_val("rd_data", 64'(bus.rd_data), 64'(q[0]));
        end
    endtask

    task automatic tick(input logic f, input logic w, input logic [DATW-1:0] d,
                        input logic r);
        bus.flush   = f;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        model_exp();
        @(posedge clk);
        if (!rst || f) begin
            q.delete();
            qt.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = w && !e_wr_vld;
            m_udf = r && !e_rd_vld;
            if (r && e_rd_vld) begin
                void'(q.pop_front());
                void'(qt.pop_front());
            end
            if (w && e_wr_vld) begin
                q.push_back(d);
                qt.push_back(cyc);
            end
        end
        cyc++;
        #1;
        compare_all();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        // reset held with writes requested: nothing is stored
        rst = 1'b0;
        repeat (3) tick(1'b0, 1'b1, 16'hDEAD, 1'b0);
        check_val("rst_rd_data",  64'(bus.rd_data),      64'h0);
        check_val("rst_aempty",   64'(bus.almost_empty), 64'h1);
        check_val("rst_wr_vld",   64'(bus.wr_vld),       64'h1);
        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("idle_count",   64'(bus.count),        64'h0);
        check_val("idle_rd_vld",  64'(bus.rd_vld),       64'h0);

        // write latency: count at c+1, data at c+2
        tick(1'b0, 1'b1, 16'h00A5, 1'b0);
        check_val("lat_cnt_c1",   64'(bus.count),        64'h1);
        check_val("lat_vld_c1",   64'(bus.rd_vld),       64'h0);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("lat_vld_c2",   64'(bus.rd_vld),       64'h1);
        check_val("lat_data_c2",  64'(bus.rd_data),      64'h00A5);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        check_val("lat_pop_vld",  64'(bus.rd_vld),       64'h0);
        check_val("lat_pop_cnt",  64'(bus.count),        64'h0);

        // fill to capacity, overflow, drain, underflow
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 16'(i), 1'b0);
            if (i == 6) check_val("fill_af_at7", 64'(bus.almost_full), 64'h0);
            if (i == 7) check_val("fill_af_at8", 64'(bus.almost_full), 64'h1);
        end
        check_val("full_wr_vld",  64'(bus.wr_vld),       64'h0);
        check_val("full_count",   64'(bus.count),        64'd16);
        check_val("full_af",      64'(bus.almost_full),  64'h1);
        tick(1'b0, 1'b1, 16'h0099, 1'b0);
        check_val("ovf_pulse",    64'(bus.overflow),     64'h1);
        check_val("ovf_count",    64'(bus.count),        64'd16);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("ovf_clear",    64'(bus.overflow),     64'h0);
        for (int i = 0; i < 16; i++) begin
            check_val("drain_data", 64'(bus.rd_data), 64'(i));
            tick(1'b0, 1'b0, 16'h0, 1'b1);
        end
        check_val("drain_vld",    64'(bus.rd_vld),       64'h0);
        check_val("drain_cnt",    64'(bus.count),        64'h0);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        check_val("udf_pulse",    64'(bus.underflow),    64'h1);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("udf_clear",    64'(bus.underflow),    64'h0);

        // streaming: one write and one pop per cycle, 1000 cycles
        tick(1'b0, 1'b1, 16'd0, 1'b0);
        tick(1'b0, 1'b1, 16'd1, 1'b0);
        check_val("strm_start",   64'(bus.rd_vld),       64'h1);
        for (int k = 0; k < 1000; k++) begin
            tick(1'b0, 1'b1, 16'(k + 2), 1'b1);
            check_val("strm_vld",  64'(bus.rd_vld),  64'h1);
            check_val("strm_cnt",  64'(bus.count),   64'd2);
            check_val("strm_data", 64'(bus.rd_data), 64'(k + 1));
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        check_val("strm_end_cnt", 64'(bus.count),        64'h0);

        // flush with 5 words held and wr_en/rd_en asserted
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("pre_flush_cnt", 64'(bus.count),       64'd5);
        tick(1'b1, 1'b1, 16'hBEEF, 1'b1);
        check_val("flush_cnt",    64'(bus.count),        64'h0);
        check_val("flush_vld",    64'(bus.rd_vld),       64'h0);
        check_val("flush_ae",     64'(bus.almost_empty), 64'h1);
        check_val("flush_ovf",    64'(bus.overflow),     64'h0);
        check_val("flush_udf",    64'(bus.underflow),    64'h0);
        tick(1'b0, 1'b1, 16'h5A5A, 1'b0);
        check_val("post_fl_c1",   64'(bus.rd_vld),       64'h0);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("post_fl_vld",  64'(bus.rd_vld),       64'h1);
        check_val("post_fl_data", 64'(bus.rd_data),      64'h5A5A);
        tick(1'b0, 1'b0, 16'h0, 1'b1);

        // random traffic against the model, biased phases to hit full/empty
        for (int n = 0; n < 3000; n++) begin
            logic f, w, r;
            int   bias;
            bias = (n / 250) % 3;
            f = ($urandom_range(0, 99) == 0);
            w = ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2)));
            r = ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2)));
            tick(f, w, 16'($urandom), r);
        end

        // mid-stream reset discards everything
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'(16'h0300 + i), 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b1, 16'h0777, 1'b1);
        rst = 1'b1;
        check_val("mrst_cnt",     64'(bus.count),        64'h0);
        check_val("mrst_data",    64'(bus.rd_data),      64'h0);
        repeat (3) tick(1'b0, 1'b0, 16'h0, 1'b0);
        check_val("mrst_vld",     64'(bus.rd_vld),       64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_fifo_prefetch_ctrl.md
# fft_fifo_prefetch_ctrl

Parametrised single-clock prefetch (first-word-fall-through) FIFO with occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and overflow/underflow reporting. It is the next-generation buffer between FFT stages and the spectrum post-processing path. It replaces fixed-size prefetch FIFO instances, and upstream/downstream flow control uses its threshold flags.

## Interface
Parameters:
- DEPTH_WIDTH, 11, log2 of capacity; capacity = 2**DEPTH_WIDTH words; legal 4..16
- DATA_WIDTH, 64, word width; legal 1..1152
- AFULL_TH, 2**DEPTH_WIDTH-8, almost_full asserts when count >= AFULL_TH
- AEMPTY_TH, 8, almost_empty asserts when count <= AEMPTY_TH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents and pointers, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- wr_vld  out  1  space available (not full); a write is accepted when wr_en & wr_vld
- rd_en  in  1  pop request; a pop occurs when rd_en & rd_vld
- rd_vld  out  1  rd_data holds the head word
- rd_data  out  DATA_WIDTH  head word (FWFT)
- count  out  DEPTH_WIDTH+1  words held, including the word presented on rd_data
- almost_full  out  1  registered threshold flag
- almost_empty  out  1  registered threshold flag
- overflow  out  1  one-cycle pulse: wr_en while wr_vld=0
- underflow  out  1  one-cycle pulse: rd_en while rd_vld=0

## Operation
- Storage: RAM array of 2**DEPTH_WIDTH words plus a prefetch output register. The output register holds the head and is counted in count. Total capacity is exactly 2**DEPTH_WIDTH.
- Pointers: DEPTH_WIDTH+1 bits each; the MSB resolves full vs empty on wrap. Pointers wrap modulo 2**DEPTH_WIDTH with no gap.
- Prefetch states: EMPTY (output register invalid), LOADING (RAM read issued, register not yet valid), VALID (rd_vld=1).
  - EMPTY->LOADING when RAM is non-empty.
  - LOADING->VALID next cycle.
  - VALID->VALID on pop when RAM is non-empty (back-to-back reads, one word per cycle).
  - VALID->LOADING on pop when RAM is empty but a write is landing.
  - VALID->EMPTY on pop with nothing pending.
- count: +1 on accepted write, -1 on pop, unchanged when both happen, saturating never required (protected by wr_vld/rd_vld).
- wr_vld = (count != 2**DEPTH_WIDTH), taken from registered count only. A write arriving while full is dropped even if a pop happens in the same cycle; overflow pulses.
- A pop attempt while rd_vld=0 is ignored; underflow pulses. A simultaneous write is still accepted.
- almost_full/almost_empty are computed from the next-count value and registered, so they track count with no extra lag.
- Data integrity: words leave in exact write order; no duplication, no loss of accepted words.

## Timing
- Reset (rst=0 sampled at a rising edge): pointers=0, count=0, rd_vld=0, rd_data=0, wr_vld=1, almost_full=0, almost_empty=1, overflow=0, underflow=0, prefetch state EMPTY.
- flush=1: identical effect to reset on the next edge. flush has priority over same-cycle wr_en/rd_en; no overflow or underflow pulse is generated. rst has priority over flush.
- Reset or flush mid-stream discards all contents, including the output register. No word written before the reset/flush edge ever appears after it.
- Write latency into an empty FIFO: wr_en accepted in cycle c -> rd_vld=1 and rd_data valid in cycle c+2. count=1 in cycle c+1.
- Sustained throughput: 1 write and 1 pop per cycle with no bubbles once rd_vld=1.
- Pop: rd_en & rd_vld in cycle c -> next word on rd_data in cycle c+1, or rd_vld=0 in cycle c+1 if that was the last word.
- overflow and underflow assert in cycle c+1 for an offending request in cycle c, for one cycle per offending cycle.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles with wr_en=1 -> all outputs at reset values, count=0, no word appears after release.
- Latency: DEPTH_WIDTH=4, write 0xA5 at cycle 10 -> rd_vld=1, rd_data=0xA5 at cycle 12; count=1 at cycle 11.
- Fill/wrap: write 16 words 0..15 with rd_en=0 -> wr_vld=0, count=16, almost_full=1 (AFULL_TH=8). A 17th write pulses overflow and is dropped. Drain -> 0..15 in order, then underflow on one extra rd_en.
- Streaming: 1000 consecutive cycles of write and pop with an incrementing pattern -> no bubbles after startup, count constant, pointers wrap more than 60 times, order preserved.
- Flush mid-operation: 5 words held, flush=1 with wr_en=1 and rd_en=1 -> next cycle count=0, rd_vld=0, almost_empty=1, no pulses. The next write appears two cycles later with its own data.
- Random: random wr_en/rd_en against a scoreboard model -> data order, count, flags and pulses match every cycle.
